// File: rtl/lut_writer_pkg.sv
// Shared opcodes, response codes and FSM states for the key/data pair table writer.
package lut_writer_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_DELETE = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_NEW      = 3'd0,
    ST_UPD      = 3'd1,
    ST_DEL      = 3'd2,
    ST_CLR      = 3'd3,
    ST_FULL     = 3'd4,
    ST_NOTFOUND = 3'd5,
    ST_BADKEY   = 3'd6,
    ST_BADOP    = 3'd7
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Slot index width; a single-slot table still needs one bit.
  function automatic int slot_width(input int nr_key);
    return (nr_key <= 1) ? 1 : $clog2(nr_key);
  endfunction

endpackage

// File: rtl/lut_writer.sv
// Owns the packed key/data table of a runtime-programmable key mux. Requests are scanned
// one slot per cycle, committed in a single edge, then answered with a one-cycle response.
module lut_writer
  import lut_writer_pkg::*;
#(
  parameter int          NR_KEY   = 2,
  parameter int          KEY_LEN  = 1,
  parameter int          DATA_LEN = 1,
  parameter int unsigned FILL_KEY = 0,
  localparam int         SW       = slot_width(NR_KEY),
  localparam int         P        = KEY_LEN + DATA_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [KEY_LEN-1:0]   req_key,
  input  logic [DATA_LEN-1:0]  req_data,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_status,
  output logic [SW-1:0]        rsp_slot,
  output logic [SW:0]          count,
  output logic [NR_KEY*P-1:0]  lut
);

  localparam logic [KEY_LEN-1:0] FILL = KEY_LEN'(FILL_KEY);

  state_e                state_reg, state_next;
  op_e                   op_reg;
  logic [KEY_LEN-1:0]    key_lat_reg;
  logic [DATA_LEN-1:0]   data_lat_reg;
  logic [SW:0]           idx_reg;
  logic                  hit_reg;
  logic [SW-1:0]         hit_slot_reg;
  logic                  free_found_reg;
  logic [SW-1:0]         free_slot_reg;
  logic [SW:0]           count_reg;
  status_e               rsp_status_reg;
  logic [SW-1:0]         rsp_slot_reg;

  logic [NR_KEY*KEY_LEN-1:0] key_vec;
  logic [NR_KEY-1:0]         occ_vec;

  logic                  handshake;
  op_e                   req_op_e;
  logic                  req_bad;
  status_e               req_bad_status;
  logic                  in_range;
  logic [SW-1:0]         idx_slot;
  logic                  scan_hit;
  logic                  scan_free;
  status_e               commit_status;
  logic [SW-1:0]         commit_slot;

  assign req_ready  = (state_reg == S_IDLE);
  assign handshake  = req_valid && req_ready;
  assign req_op_e   = op_e'(req_op);
  assign rsp_valid  = (state_reg == S_RESP);
  assign rsp_status = rsp_status_reg;
  assign rsp_slot   = rsp_slot_reg;
  assign count      = count_reg;

  // Reserved opcode takes priority over a reserved key; CLEAR ignores the key entirely.
  always_comb begin
    req_bad        = 1'b0;
    req_bad_status = ST_BADOP;
    if (req_op_e == OP_RSVD) begin
      req_bad = 1'b1;
    end else if (req_op_e != OP_CLEAR && req_key == FILL) begin
      req_bad        = 1'b1;
      req_bad_status = ST_BADKEY;
    end
  end

  // The scan runs one step past the last slot so that a miss costs NR_KEY+1 scan cycles.
  always_comb begin
    in_range  = (idx_reg < (SW+1)'(NR_KEY));
    idx_slot  = idx_reg[SW-1:0];
    scan_hit  = 1'b0;
    scan_free = 1'b0;
    if (in_range) begin
      scan_hit  = occ_vec[idx_slot] && (key_vec[idx_slot*KEY_LEN +: KEY_LEN] == key_lat_reg);
      scan_free = !occ_vec[idx_slot];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (handshake) begin
          if (req_op_e == OP_CLEAR) state_next = S_COMMIT;
          else if (req_bad)         state_next = S_RESP;
          else                      state_next = S_SCAN;
        end
      end
      S_SCAN:   if (scan_hit || !in_range) state_next = S_COMMIT;
      S_COMMIT: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    commit_status = ST_CLR;
    commit_slot   = '0;
    case (op_reg)
      OP_WRITE: begin
        if (hit_reg) begin
          commit_status = ST_UPD;
          commit_slot   = hit_slot_reg;
        end else if (free_found_reg) begin
          commit_status = ST_NEW;
          commit_slot   = free_slot_reg;
        end else begin
          commit_status = ST_FULL;
        end
      end
      OP_DELETE: begin
        if (hit_reg) begin
          commit_status = ST_DEL;
          commit_slot   = hit_slot_reg;
        end else begin
          commit_status = ST_NOTFOUND;
        end
      end
      default: commit_status = ST_CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg         <= OP_WRITE;
      key_lat_reg    <= '0;
      data_lat_reg   <= '0;
      idx_reg        <= '0;
      hit_reg        <= 1'b0;
      hit_slot_reg   <= '0;
      free_found_reg <= 1'b0;
      free_slot_reg  <= '0;
      count_reg      <= '0;
      rsp_status_reg <= ST_NEW;
      rsp_slot_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (handshake) begin
            op_reg         <= req_op_e;
            key_lat_reg    <= req_key;
            data_lat_reg   <= req_data;
            idx_reg        <= '0;
            hit_reg        <= 1'b0;
            free_found_reg <= 1'b0;
            if (req_bad && req_op_e != OP_CLEAR) begin
              rsp_status_reg <= req_bad_status;
              rsp_slot_reg   <= '0;
            end
          end
        end
        S_SCAN: begin
          if (in_range) begin
            idx_reg <= idx_reg + (SW+1)'(1);
            if (scan_hit) begin
              hit_reg      <= 1'b1;
              hit_slot_reg <= idx_slot;
            end else if (scan_free && !free_found_reg) begin
              free_found_reg <= 1'b1;
              free_slot_reg  <= idx_slot;
            end
          end
        end
        S_COMMIT: begin
          rsp_status_reg <= commit_status;
          rsp_slot_reg   <= commit_slot;
          if (commit_status == ST_CLR)      count_reg <= '0;
          else if (commit_status == ST_NEW) count_reg <= count_reg + (SW+1)'(1);
          else if (commit_status == ST_DEL) count_reg <= count_reg - (SW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Per-slot storage; every slot change happens on the edge leaving COMMIT.
  genvar gi;
  generate
    for (gi = 0; gi < NR_KEY; gi++) begin : slot_g
      logic [KEY_LEN-1:0]  key_reg;
      logic [DATA_LEN-1:0] data_reg;
      logic                occ_reg;
      logic                is_hit;
      logic                is_free;

      assign is_hit  = hit_reg && (hit_slot_reg == SW'(gi));
      assign is_free = !hit_reg && free_found_reg && (free_slot_reg == SW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          key_reg  <= FILL;
          data_reg <= '0;
          occ_reg  <= 1'b0;
        end else if (state_reg == S_COMMIT) begin
          if (op_reg == OP_CLEAR || (op_reg == OP_DELETE && is_hit)) begin
            key_reg  <= FILL;
            data_reg <= '0;
            occ_reg  <= 1'b0;
          end else if (op_reg == OP_WRITE && is_hit) begin
            data_reg <= data_lat_reg;
          end else if (op_reg == OP_WRITE && is_free) begin
            key_reg  <= key_lat_reg;
            data_reg <= data_lat_reg;
            occ_reg  <= 1'b1;
          end
        end
      end

      assign lut[P*gi +: P]                = {key_reg, data_reg};
      assign key_vec[KEY_LEN*gi +: KEY_LEN] = key_reg;
      assign occ_vec[gi]                    = occ_reg;
    end
  endgenerate

endmodule

// File: tb/tb_lut_writer.sv
// Self-checking bench for lut_writer: directed vector table, reset-abort sequence,
// then random requests checked against a slot-table reference model.
module tb_lut_writer;

  localparam int NR = 4;
  localparam int KL = 4;
  localparam int DL = 8;
  localparam int P  = KL + DL;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'd0;
  logic [KL-1:0]     req_key = '0;
  logic [DL-1:0]     req_data = '0;
  logic              rsp_valid;
  logic [2:0]        rsp_status;
  logic [SW-1:0]     rsp_slot;
  logic [SW:0]       count;
  logic [NR*P-1:0]   lut;

  lut_writer #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL), .FILL_KEY(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_key(req_key), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_slot(rsp_slot), .count(count), .lut(lut)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference table: plain arrays of pairs plus an occupied flag.
  logic [KL-1:0] m_key  [NR];
  logic [DL-1:0] m_data [NR];
  bit            m_occ  [NR];

  typedef struct {
    logic [1:0]    op;
    logic [KL-1:0] key;
    logic [DL-1:0] data;
    logic [2:0]    st;
    int            slot;
    int            lat;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_key[i] = '0; m_data[i] = '0; m_occ[i] = 1'b0;
    end
  endfunction

  function automatic logic [NR*P-1:0] model_lut();
    logic [NR*P-1:0] v = '0;
    for (int i = 0; i < NR; i++)
      if (m_occ[i]) v[i*P +: P] = {m_key[i], m_data[i]};
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += m_occ[i];
    return c;
  endfunction

  function automatic void model_apply(input logic [1:0] op, input logic [KL-1:0] k,
                                      input logic [DL-1:0] d, output logic [2:0] st,
                                      output int slot, output int lat);
    int hit = -1;
    int fr  = -1;
    slot = 0;
    if (op == 2'd3) begin st = 3'd7; lat = 1; return; end
    if (op == 2'd2) begin model_reset(); st = 3'd3; lat = 2; return; end
    if (k == 0) begin st = 3'd6; lat = 1; return; end
    for (int i = 0; i < NR; i++) begin
      if (m_occ[i] && m_key[i] == k && hit < 0) hit = i;
      if (!m_occ[i] && fr < 0) fr = i;
    end
    lat = (hit >= 0) ? hit + 3 : NR + 3;
    if (op == 2'd0) begin
      if (hit >= 0) begin m_data[hit] = d; st = 3'd1; slot = hit; end
      else if (fr >= 0) begin m_key[fr] = k; m_data[fr] = d; m_occ[fr] = 1'b1; st = 3'd0; slot = fr; end
      else st = 3'd4;
    end else begin
      if (hit >= 0) begin m_occ[hit] = 1'b0; m_key[hit] = '0; m_data[hit] = '0; st = 3'd2; slot = hit; end
      else st = 3'd5;
    end
  endfunction

  task automatic run_txn(input string name, input logic [1:0] op, input logic [KL-1:0] k,
                         input logic [DL-1:0] d, input logic [2:0] exp_st,
                         input int exp_slot, input int exp_lat);
    int  cyc;
    bit  seen = 1'b0;
    @(negedge clk);
    check({name, ".ready"}, req_ready, 1);
    req_valid = 1'b1; req_op = op; req_key = k; req_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    check({name, ".lat"}, seen ? cyc : 0, exp_lat);
    check({name, ".status"}, rsp_status, exp_st);
    check({name, ".slot"}, rsp_slot, exp_slot);
    check({name, ".lut"}, lut, model_lut());
    check({name, ".count"}, count, model_count());
    $display("txn %s op=%0d key=%0h data=%0h -> status=%0d slot=%0d lat=%0d count=%0d",
             name, op, k, d, rsp_status, rsp_slot, seen ? cyc : 0, count);
    @(negedge clk);
    check({name, ".pulse"}, rsp_valid, 0);
  endtask

  initial begin
    logic [2:0] st;
    int         slot;
    int         lat;
    int         r;
    logic [1:0] op;
    logic [KL-1:0] k;
    logic [DL-1:0] d;

    //          op    key   data   st    slot lat
    vecs[0]  = '{2'd0, 4'h3, 8'hAA, 3'd0, 0, 7};  // new pair into empty table
    vecs[1]  = '{2'd0, 4'h3, 8'h55, 3'd1, 0, 3};  // update hit at slot 0
    vecs[2]  = '{2'd1, 4'h3, 8'h00, 3'd2, 0, 3};  // delete it again
    vecs[3]  = '{2'd0, 4'h1, 8'h11, 3'd0, 0, 7};
    vecs[4]  = '{2'd0, 4'h2, 8'h22, 3'd0, 1, 7};
    vecs[5]  = '{2'd0, 4'h4, 8'h44, 3'd0, 2, 7};
    vecs[6]  = '{2'd0, 4'h5, 8'h55, 3'd0, 3, 7};
    vecs[7]  = '{2'd0, 4'h6, 8'h66, 3'd4, 0, 7};  // table full
    vecs[8]  = '{2'd0, 4'h5, 8'hC3, 3'd1, 3, 6};  // hit at last slot
    vecs[9]  = '{2'd1, 4'h2, 8'h00, 3'd2, 1, 4};
    vecs[10] = '{2'd0, 4'h7, 8'h77, 3'd0, 1, 7};  // reuse the freed hole
    vecs[11] = '{2'd1, 4'h9, 8'h00, 3'd5, 0, 7};
    vecs[12] = '{2'd0, 4'h0, 8'h12, 3'd6, 0, 1};  // reserved key
    vecs[13] = '{2'd3, 4'h5, 8'h00, 3'd7, 0, 1};  // reserved op
    vecs[14] = '{2'd2, 4'h0, 8'h00, 3'd3, 0, 2};  // clear

    model_reset();
    repeat (2) @(negedge clk);
    check("reset.lut", lut, 0);
    check("reset.count", count, 0);
    check("reset.ready", req_ready, 1);
    check("reset.rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      model_apply(vecs[i].op, vecs[i].key, vecs[i].data, st, slot, lat);
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].key, vecs[i].data,
              vecs[i].st, vecs[i].slot, vecs[i].lat);
    end

    // Reset asserted while a WRITE is mid-scan must abort it and wipe the table.
    model_apply(2'd0, 4'h1, 8'h5A, st, slot, lat);
    run_txn("pre_abort", 2'd0, 4'h1, 8'h5A, st, slot, lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_key = 4'h8; req_data = 8'h81;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.lut", lut, 0);
    check("abort.count", count, 0);
    check("abort.ready", req_ready, 1);
    check("abort.rsp_valid", rsp_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (rsp_valid) pulses++;
      end
      check("abort.no_rsp", pulses, 0);
      check("abort.lut_after", lut, 0);
      $display("txn abort: reset during scan of key 8, rsp pulses after release=%0d", pulses);
    end

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 4) ? 2'd2 : (r < 8) ? 2'd3 : (r < 60) ? 2'd0 : 2'd1;
      k  = 4'($urandom_range(0, 7));
      d  = 8'($urandom_range(0, 255));
      model_apply(op, k, d, st, slot, lat);
      run_txn($sformatf("rnd%0d", i), op, k, d, st, slot, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
